pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 8-bit 5-stage core. It drives the PC write enable, the IF/ID write_en/flush pair and the ID/EX flush from the hazard sources: load-use, taken branch, memory wait and external interrupt.
It owns a small FSM that sequences memory freeze and interrupt entry (drain, then vector). It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-source inputs and pipeline-control outputs of the hazard controller.
// The pipeline side is the master; the controller is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 2,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_ra;
    logic [REG_W-1:0] id_rb;
    logic             id_uses_ra;
    logic             id_uses_rb;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             irq;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pc_sel_int;
    logic             irq_ack;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_ra, id_rb, id_uses_ra, id_uses_rb, ex_mem_read, ex_rd,
               ex_branch_taken, mem_busy, irq,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_flush,
               pc_sel_int, irq_ack, stall_cnt
    );

    modport slave (
        input  id_ra, id_rb, id_uses_ra, id_uses_rb, ex_mem_read, ex_rd,
               ex_branch_taken, mem_busy, irq,
        output pc_write_en, ifid_write_en, ifid_flush, idex_flush,
               pc_sel_int, irq_ack, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch flush, memory freeze and
// interrupt entry (drain, then vector), plus a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int REG_W        = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, INT_DRAIN, INT_VECTOR} state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t           state_reg, state_next;
    logic [3:0]       drain_reg, drain_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic pc_we, ifid_we, ifid_fl, idex_fl, sel_int, ack;

    // Load-use detection, one comparator per ID source operand.
    logic [REG_W-1:0] src_reg [2];
    logic [1:0]       src_use;
    logic [1:0]       src_hit;
    logic             lu;

    assign src_reg[0] = hz.id_ra;
    assign src_reg[1] = hz.id_rb;
    assign src_use    = {hz.id_uses_rb, hz.id_uses_ra};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_reg[gi] == hz.ex_rd);
        end
    endgenerate

    assign lu = hz.ex_mem_read && (|src_hit);

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_fl    = 1'b0;
        idex_fl    = 1'b0;
        sel_int    = 1'b0;
        ack        = 1'b0;
        state_next = state_reg;
        drain_next = drain_reg;

        if (!rst) begin
            if (hz.mem_busy) begin
                // Freeze overrides everything; drain counter and vector are held.
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                if (state_reg == RUN)
                    state_next = MEM_WAIT;
            end else begin
                case (state_reg)
                    RUN, MEM_WAIT: begin
                        state_next = RUN;
                        if (hz.ex_branch_taken) begin
                            ifid_fl = 1'b1;
                            idex_fl = 1'b1;
                        end else if (lu) begin
                            pc_we   = 1'b0;
                            ifid_we = 1'b0;
                            idex_fl = 1'b1;
                        end else if (hz.irq) begin
                            pc_we      = 1'b0;
                            ifid_fl    = 1'b1;
                            state_next = INT_DRAIN;
                            drain_next = DRAIN_INIT;
                        end
                    end
                    INT_DRAIN: begin
                        // A taken branch still redirects the PC so the saved
                        // return address becomes the branch target.
                        pc_we      = hz.ex_branch_taken;
                        ifid_fl    = 1'b1;
                        idex_fl    = hz.ex_branch_taken;
                        drain_next = drain_reg - 4'd1;
                        if (drain_reg == 4'd1)
                            state_next = INT_VECTOR;
                    end
                    INT_VECTOR: begin
                        sel_int    = 1'b1;
                        ifid_fl    = 1'b1;
                        ack        = 1'b1;
                        state_next = RUN;
                    end
                    default: state_next = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            drain_reg     <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            if (!pc_we && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign hz.pc_write_en   = pc_we;
    assign hz.ifid_write_en = ifid_we;
    assign hz.ifid_flush    = ifid_fl;
    assign hz.idex_flush    = idex_fl;
    assign hz.pc_sel_int    = sel_int;
    assign hz.irq_ack       = ack;
    assign hz.stall_cnt     = stall_cnt_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written reset and
// saturation sequences, then randomized cycles against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int DRAIN = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       busy;
        logic       irq;
        logic       mr;
        logic [1:0] rd;
        logic       ura;
        logic [1:0] ra;
        logic       urb;
        logic [1:0] rb;
    } in_t;

    typedef struct packed {
        logic [5:0]    ctl;   // {pc_we, ifid_we, ifid_flush, idex_flush, pc_sel_int, irq_ack}
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [5:0] NRM = 6'b110000;
    localparam logic [5:0] FRZ = 6'b000000;
    localparam logic [5:0] LUS = 6'b000100;
    localparam logic [5:0] BRF = 6'b111100;
    localparam logic [5:0] DRN = 6'b011000;
    localparam logic [5:0] VEC = 6'b111011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if #(.REG_W(2), .CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.REG_W(2), .DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic r, b, bs, q, m, input logic [1:0] d,
                               input logic ua, input logic [1:0] a,
                               input logic ub, input logic [1:0] bb);
        in_t v;
        v.rst = r; v.br = b; v.busy = bs; v.irq = q; v.mr = m; v.rd = d;
        v.ura = ua; v.ra = a; v.urb = ub; v.rb = bb;
        return v;
    endfunction

    function automatic in_t c(input logic r, b, bs, q);
        return mk(r, b, bs, q, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    endfunction

    function automatic out_t o(input logic [5:0] ctl, input int cnt);
        out_t e;
        e.ctl = ctl;
        e.cnt = CW'(cnt);
        return e;
    endfunction

    vec_t tbl[$];

    task automatic add(input in_t v, input out_t e);
        vec_t t;
        t.i = v;
        t.o = e;
        tbl.push_back(t);
    endtask

    task automatic drive(input in_t v);
        rst                = v.rst;
        hz.ex_branch_taken = v.br;
        hz.mem_busy        = v.busy;
        hz.irq             = v.irq;
        hz.ex_mem_read     = v.mr;
        hz.ex_rd           = v.rd;
        hz.id_uses_ra      = v.ura;
        hz.id_ra           = v.ra;
        hz.id_uses_rb      = v.urb;
        hz.id_rb           = v.rb;
    endtask

    // Applies one cycle of inputs at posedge+1, compares at posedge+2, then
    // advances past the next rising edge.
    task automatic run_cycle(input in_t v, input out_t e, input string tag);
        out_t act;
        drive(v);
        #1;
        act.ctl = {hz.pc_write_en, hz.ifid_write_en, hz.ifid_flush, hz.idex_flush,
                   hz.pc_sel_int, hz.irq_ack};
        act.cnt = hz.stall_cnt;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s in=%b got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                     tag, v, act.ctl, act.cnt, e.ctl, e.cnt);
        end else begin
            $display("ok   %s in=%b ctl=%b cnt=%0d", tag, v, act.ctl, act.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: an interrupt is a run of DRAIN+1 non-busy cycles, the
    // last of which is the vector; memory-wait needs no state of its own.
    int m_int_left = 0;
    int m_cnt      = 0;

    function automatic out_t ref_out(input in_t v);
        logic lu;
        lu = v.mr && ((v.ura && v.ra == v.rd) || (v.urb && v.rb == v.rd));
        if (v.rst)                  return o(NRM, m_cnt);
        if (v.busy)                 return o(FRZ, m_cnt);
        if (m_int_left == 1)        return o(VEC, m_cnt);
        if (m_int_left > 1)         return o(v.br ? BRF : DRN, m_cnt);
        if (v.br)                   return o(BRF, m_cnt);
        if (lu)                     return o(LUS, m_cnt);
        if (v.irq)                  return o(DRN, m_cnt);
        return o(NRM, m_cnt);
    endfunction

    task automatic ref_step(input in_t v, input out_t e);
        logic lu;
        lu = v.mr && ((v.ura && v.ra == v.rd) || (v.urb && v.rb == v.rd));
        if (v.rst) begin
            m_int_left = 0;
            m_cnt      = 0;
        end else begin
            if (!e.ctl[5] && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (!v.busy) begin
                if (m_int_left > 0)          m_int_left = m_int_left - 1;
                else if (!v.br && !lu && v.irq) m_int_left = DRAIN + 1;
            end
        end
    endtask

    initial begin
        in_t  v;
        out_t e;

        drive(c(1, 0, 0, 0));

        // Directed table; cnt column is the registered count seen that cycle.
        add(c(1,0,0,0), o(NRM, 0));
        add(c(1,0,0,0), o(NRM, 0));
        add(c(0,0,0,0), o(NRM, 0));
        add(mk(0,0,0,0, 1,2'd2, 1,2'd2, 0,2'd0), o(LUS, 0));
        add(c(0,0,0,0), o(NRM, 1));
        add(mk(0,0,0,0, 1,2'd2, 0,2'd2, 0,2'd0), o(NRM, 1));
        add(mk(0,0,0,0, 1,2'd3, 0,2'd0, 1,2'd3), o(LUS, 1));
        add(c(0,0,0,0), o(NRM, 2));
        add(mk(0,1,0,0, 1,2'd1, 1,2'd1, 0,2'd0), o(BRF, 2));
        add(c(0,0,0,0), o(NRM, 2));
        add(c(0,1,1,0), o(FRZ, 2));
        add(c(0,1,1,0), o(FRZ, 3));
        add(c(0,1,1,0), o(FRZ, 4));
        add(c(0,1,0,0), o(BRF, 5));
        add(c(0,0,0,0), o(NRM, 5));
        add(c(0,0,0,1), o(DRN, 5));
        add(c(0,0,0,0), o(DRN, 6));
        add(c(0,0,0,0), o(DRN, 7));
        add(c(0,0,0,0), o(DRN, 8));
        add(c(0,0,0,0), o(VEC, 9));
        add(c(0,0,0,0), o(NRM, 9));
        add(c(0,0,0,1), o(DRN, 9));
        add(c(0,0,0,0), o(DRN, 10));
        add(c(0,0,1,0), o(FRZ, 11));
        add(c(0,0,1,0), o(FRZ, 12));
        add(c(0,0,0,0), o(DRN, 13));
        add(c(0,0,0,0), o(DRN, 14));
        add(c(0,0,0,0), o(VEC, 15));
        add(c(0,0,0,0), o(NRM, 15));
        add(c(0,0,0,1), o(DRN, 15));
        add(c(0,1,0,0), o(BRF, 15));
        add(c(0,0,0,0), o(DRN, 15));
        add(c(0,0,0,0), o(DRN, 15));
        add(c(0,0,0,0), o(VEC, 15));
        add(c(0,0,0,0), o(NRM, 15));
        add(c(1,0,0,0), o(NRM, 15));
        add(c(0,0,0,0), o(NRM, 0));
        add(c(0,0,1,1), o(FRZ, 0));
        add(c(0,0,0,1), o(DRN, 1));
        add(mk(0,0,0,0, 1,2'd0, 1,2'd0, 0,2'd0), o(DRN, 2));
        add(c(0,0,0,0), o(DRN, 3));
        add(c(0,0,0,0), o(DRN, 4));
        add(c(0,0,1,0), o(FRZ, 5));
        add(c(0,0,0,0), o(VEC, 6));
        add(c(0,0,0,0), o(NRM, 6));
        add(c(0,1,0,1), o(BRF, 6));
        add(c(0,0,0,1), o(DRN, 6));
        add(c(0,0,0,0), o(DRN, 7));
        add(c(0,0,0,0), o(DRN, 8));
        add(c(0,0,0,0), o(DRN, 9));
        add(c(0,0,0,0), o(VEC, 10));
        add(c(0,0,0,0), o(NRM, 10));

        @(posedge clk);
        #1;
        foreach (tbl[k])
            run_cycle(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

        // Reset in the middle of a drain: no vector or ack may follow.
        run_cycle(c(1,0,0,0), o(NRM, 10), "rstdrain_rst0");
        run_cycle(c(0,0,0,0), o(NRM, 0),  "rstdrain_idle");
        run_cycle(c(0,0,0,1), o(DRN, 0),  "rstdrain_irq");
        run_cycle(c(0,0,0,0), o(DRN, 1),  "rstdrain_d1");
        run_cycle(c(1,0,0,0), o(NRM, 2),  "rstdrain_rst");
        for (int k = 0; k < 6; k++)
            run_cycle(c(0,0,0,0), o(NRM, 0), $sformatf("rstdrain_after%0d", k));

        // Long freeze drives the counter into saturation.
        for (int k = 0; k < 20; k++)
            run_cycle(c(0,0,1,0), o(FRZ, (k < CMAX) ? k : CMAX), $sformatf("sat%0d", k));
        run_cycle(c(0,0,0,0), o(NRM, CMAX), "sat_hold");
        run_cycle(c(1,0,0,0), o(NRM, CMAX), "sat_rst");
        run_cycle(c(0,0,0,0), o(NRM, 0),    "sat_clear");

        // Randomized cycles against the model, starting from RUN with count 0.
        m_int_left = 0;
        m_cnt      = 0;
        for (int k = 0; k < 400; k++) begin
            v.rst  = ($urandom_range(0, 63) == 0);
            v.br   = ($urandom_range(0, 5) == 0);
            v.busy = ($urandom_range(0, 4) == 0);
            v.irq  = ($urandom_range(0, 7) == 0);
            v.mr   = ($urandom_range(0, 2) == 0);
            v.rd   = 2'($urandom_range(0, 3));
            v.ura  = 1'($urandom_range(0, 1));
            v.ra   = 2'($urandom_range(0, 3));
            v.urb  = 1'($urandom_range(0, 1));
            v.rb   = 2'($urandom_range(0, 3));
            e = ref_out(v);
            run_cycle(v, e, $sformatf("rnd%0d", k));
            ref_step(v, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
